// File: rtl/sighash_preimage_parser.sv
// sighash_preimage_parser
//
// Streaming decoder for the 390-byte split-transaction sighash preimage
// (BIP143 layout with a fixed 234-byte script). Bytes arrive one per beat
// over a valid/ready stream and are shifted into a 3120-bit register. The
// eleven fields are fixed, big-endian slices of that register. The first
// byte of each field is its MSB.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  byte stream handshake; in_data byte, in_last frame end
//   out_valid/ready decoded-field handshake; out_valid held until out_ready
//   nversion .. sighash_type   decoded fields (bytes 0..389 of the frame)
//   type_ok         sighash_type == EXPECT_SIGHASH_TYPE, valid with out_valid
//   err             one-cycle pulse on a framing error
//
// state | meaning
// IDLE  | waiting for byte 0, counter = 0
// RECV  | receiving bytes 1..389
// DONE  | frame complete, fields held, in_ready = 0
// DRAIN | overlong frame, discarding bytes until in_last
module sighash_preimage_parser #(
  parameter logic [31:0] EXPECT_SIGHASH_TYPE = 32'h01000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    nversion,
  output logic [255:0]   hash_prevouts,
  output logic [255:0]   hash_sequence,
  output logic [255:0]   in_txid,
  output logic [31:0]    in_vout,
  output logic [1871:0]  script,
  output logic [63:0]    in_amount,
  output logic [31:0]    in_nseq,
  output logic [255:0]   hash_outputs,
  output logic [31:0]    locktime,
  output logic [31:0]    sighash_type,
  output logic           type_ok,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, RECV, DONE, DRAIN} state_t;

  localparam logic [8:0] LAST_IDX = 9'd389;

  state_t        state, state_nxt;
  logic [8:0]    cnt, cnt_nxt;
  logic [3119:0] sr;
  logic          accept;
  logic          shift_en;
  logic          err_nxt;
  logic          type_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    err_nxt   = 1'b0;
    type_load = 1'b0;
    in_ready  = (state != DONE);
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    case (state)
      IDLE, RECV: begin
        if (accept) begin
          shift_en = 1'b1;
          if (cnt == LAST_IDX) begin
            cnt_nxt = '0;
            if (in_last) begin
              state_nxt = DONE;
              type_load = 1'b1;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = DRAIN;
            end
          end else if (in_last) begin
            // Short frame (including a single-byte frame): drop it.
            err_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = cnt + 9'd1;
            state_nxt = RECV;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      DRAIN: begin
        // Excess bytes are consumed but never shifted into the fields.
        if (accept && in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      type_ok <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= err_nxt;
      if (shift_en) sr <= {sr[3111:0], in_data};
      // The last four bytes are the type; compare including the byte
      // arriving on this beat.
      if (type_load) type_ok <= ({sr[23:0], in_data} == EXPECT_SIGHASH_TYPE);
    end
  end

  assign nversion      = sr[3119:3088];
  assign hash_prevouts = sr[3087:2832];
  assign hash_sequence = sr[2831:2576];
  assign in_txid       = sr[2575:2320];
  assign in_vout       = sr[2319:2288];
  assign script        = sr[2287:416];
  assign in_amount     = sr[415:352];
  assign in_nseq       = sr[351:320];
  assign hash_outputs  = sr[319:64];
  assign locktime      = sr[63:32];
  assign sighash_type  = sr[31:0];

endmodule

// File: tb/tb_sighash_preimage_parser.sv
module tb_sighash_preimage_parser;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    nversion;
  logic [255:0]   hash_prevouts;
  logic [255:0]   hash_sequence;
  logic [255:0]   in_txid;
  logic [31:0]    in_vout;
  logic [1871:0]  script;
  logic [63:0]    in_amount;
  logic [31:0]    in_nseq;
  logic [255:0]   hash_outputs;
  logic [31:0]    locktime;
  logic [31:0]    sighash_type;
  logic           type_ok;
  logic           err;

  logic [3119:0]  all_f;
  logic [7:0]     frm [0:399];
  int             n_tests = 0;
  int             n_fail  = 0;

  sighash_preimage_parser dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .nversion(nversion), .hash_prevouts(hash_prevouts), .hash_sequence(hash_sequence),
    .in_txid(in_txid), .in_vout(in_vout), .script(script), .in_amount(in_amount),
    .in_nseq(in_nseq), .hash_outputs(hash_outputs), .locktime(locktime),
    .sighash_type(sighash_type), .type_ok(type_ok), .err(err)
  );

  always #5 clk = ~clk;

  assign all_f = {nversion, hash_prevouts, hash_sequence, in_txid, in_vout, script,
                  in_amount, in_nseq, hash_outputs, locktime, sighash_type};

  // Reference layout: byte i of the frame lands at bits 3119-8i downto 3112-8i.
  function automatic logic [3119:0] exp_frame();
    logic [3119:0] v;
    v = '0;
    for (int i = 0; i < 390; i++) v[3119-8*i -: 8] = frm[i];
    return v;
  endfunction

  task automatic build_frame(input int mul, input int add, input logic [7:0] t0);
    for (int i = 0; i < 400; i++) frm[i] = 8'((i * mul + add) % 256);
    frm[386] = t0; frm[387] = 8'h00; frm[388] = 8'h00; frm[389] = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    logic acc;
    in_valid = 1'b1; in_data = d; in_last = l; acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_byte_timeout in_ready=%0b required=1", in_ready);
    end
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      send_byte(frm[i], i == n - 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_tests++; if (err !== 1'b0 || type_ok !== 1'b0) begin n_fail++; $display("FAIL reset_err_type_ok got=%0b%0b exp=00", err, type_ok); end
    n_tests++; if (all_f !== '0) begin n_fail++; $display("FAIL reset_fields got_nversion=%h exp=0", nversion); end
  endtask

  task automatic test_nominal();
    build_frame(1, 0, 8'h01);
    send_frame(390, 1'b0);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nom_out_valid got=%0b exp=1", out_valid); end
    n_tests++; if (nversion !== 32'h00010203) begin n_fail++; $display("FAIL nom_nversion got=%h exp=00010203", nversion); end
    n_tests++; if (in_vout !== 32'h64656667) begin n_fail++; $display("FAIL nom_in_vout got=%h exp=64656667", in_vout); end
    n_tests++; if (sighash_type !== 32'h01000000) begin n_fail++; $display("FAIL nom_sighash_type got=%h exp=01000000", sighash_type); end
    n_tests++; if (type_ok !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL nom_type_ok_err got=%0b%0b exp=10", type_ok, err); end
    n_tests++; if (all_f !== exp_frame()) begin n_fail++; $display("FAIL nom_fields got_script_lsb=%h exp=%h", script[31:0], exp_frame() >> 416); end
    repeat (3) begin @(posedge clk); #1; end
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL nom_hold got_ready_valid=%0b%0b exp=01", in_ready, out_valid); end
    handshake();
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL nom_release got_ready_valid=%0b%0b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_wrong_type();
    build_frame(1, 0, 8'h03);
    send_frame(390, 1'b0);
    n_tests++; if (out_valid !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL wt_valid_err got=%0b%0b exp=10", out_valid, err); end
    n_tests++; if (sighash_type !== 32'h03000000) begin n_fail++; $display("FAIL wt_sighash_type got=%h exp=03000000", sighash_type); end
    n_tests++; if (type_ok !== 1'b0) begin n_fail++; $display("FAIL wt_type_ok got=%0b exp=0", type_ok); end
    handshake();
  endtask

  task automatic test_short();
    build_frame(1, 0, 8'h01);
    send_frame(101, 1'b0);
    n_tests++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL short_err got_err_valid=%0b%0b exp=10", err, out_valid); end
    @(posedge clk); #1;
    n_tests++; if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL short_after got_err_valid_ready=%0b%0b%0b exp=001", err, out_valid, in_ready); end
    build_frame(3, 5, 8'h01);
    send_frame(390, 1'b0);
    n_tests++; if (out_valid !== 1'b1 || all_f !== exp_frame() || type_ok !== 1'b1) begin n_fail++; $display("FAIL short_recover got_valid=%0b nversion=%h", out_valid, nversion); end
    handshake();
  endtask

  task automatic test_long();
    build_frame(1, 0, 8'h01);
    for (int i = 0; i < 390; i++) send_byte(frm[i], 1'b0);
    n_tests++; if (err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL long_err got_err_valid=%0b%0b exp=10", err, out_valid); end
    send_byte(frm[390], 1'b0);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL long_err_width got=%0b exp=0", err); end
    for (int i = 391; i < 395; i++) send_byte(frm[i], i == 394);
    in_valid = 1'b0; in_last = 1'b0;
    n_tests++; if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL long_end got_err_valid_ready=%0b%0b%0b exp=001", err, out_valid, in_ready); end
    build_frame(5, 11, 8'h01);
    send_frame(390, 1'b0);
    n_tests++; if (out_valid !== 1'b1 || all_f !== exp_frame()) begin n_fail++; $display("FAIL long_recover got_valid=%0b nversion=%h", out_valid, nversion); end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [3119:0] exp_a;
    build_frame(7, 3, 8'h01);
    exp_a = exp_frame();
    send_frame(390, 1'b1);
    build_frame(13, 1, 8'h01);
    in_valid = 1'b1; in_data = frm[0]; in_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || all_f !== exp_a) begin
        n_fail++; $display("FAIL bp_hold cycle=%0d got_ready_valid=%0b%0b nversion=%h", c, in_ready, out_valid, nversion);
      end
    end
    handshake();
    n_tests++; if (in_ready !== 1'b1 || all_f !== exp_a) begin n_fail++; $display("FAIL bp_after_hs got_ready=%0b nversion=%h exp_ready=1", in_ready, nversion); end
    send_frame(390, 1'b1);
    n_tests++; if (out_valid !== 1'b1 || all_f !== exp_frame()) begin n_fail++; $display("FAIL bp_second got_valid=%0b nversion=%h", out_valid, nversion); end
    handshake();
  endtask

  task automatic test_reset_mid();
    build_frame(1, 0, 8'h01);
    send_frame(201, 1'b0);
    in_valid = 1'b1; in_data = 8'hAA;
    #2 rst = 1'b1;
    #1;
    n_tests++; if (all_f !== '0 || out_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got_nversion=%h valid=%0b exp=0", nversion, out_valid); end
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    build_frame(9, 2, 8'h01);
    send_frame(390, 1'b0);
    n_tests++; if (out_valid !== 1'b1 || all_f !== exp_frame() || type_ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_recover got_valid=%0b nversion=%h", out_valid, nversion); end
    handshake();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_nominal();
    test_wrong_type();
    test_short();
    test_long();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
